// File: rtl/vec_pipe_pkg.sv
// ----------------------------------------------------------------------------
// vec_pipe_pkg
// Shared definitions for the vector CPU pipeline segments.
//   - Default lane geometry (bits per lane, lane count, register address width,
//     flag bits per lane) and default stall-counter width.
//   - Lane and flag element types.
//   - seg_entry_t: everything one pipeline segment entry carries, at the
//     default geometry.
// No ports; this file only holds types and constants.
// ----------------------------------------------------------------------------
package vec_pipe_pkg;

    localparam int LANE_N  = 8;   // bits per lane
    localparam int LANES   = 6;   // number of lanes
    localparam int ADDR_W  = 4;   // destination register address width
    localparam int FLAG_W  = 2;   // ALU flag bits per lane
    localparam int STALL_W = 16;  // stall counter width

    typedef logic [LANE_N-1:0] lane_t;
    typedef logic [FLAG_W-1:0] flags_t;

    typedef struct packed {
        logic                regwrite;
        logic                memtoreg;
        logic                flagswrite;
        logic [LANES-1:0]    lane_mask;
        logic [ADDR_W-1:0]   wa3;
        flags_t [LANES-1:0]  flags;
        lane_t  [LANES-1:0]  readdata;
        lane_t  [LANES-1:0]  aluout;
    } seg_entry_t;

endpackage

// File: rtl/seg_entry_reg.sv
// ----------------------------------------------------------------------------
// seg_entry_reg
// One entry slot of a pipeline segment: a valid bit plus a W-bit payload.
// Captures on the falling clock edge like every other pipeline segment.
//   clk    in   stage clock (falling edge active)
//   reset  in   asynchronous, active-low; clears valid and payload
//   load   in   capture d and mark the slot valid
//   clear  in   mark the slot invalid (payload kept); wins over load
//   d      in   W-bit payload to capture
//   valid  out  slot holds an entry
//   q      out  stored payload
// ----------------------------------------------------------------------------
module seg_entry_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            // Payload is left in place; only the valid bit matters downstream.
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/segment_vec_skid.sv
// ----------------------------------------------------------------------------
// segment_vec_skid
// Generic inter-stage segment of the vector CPU (used e.g. for MEM->WB).
// valid/ready handshake backed by a main entry plus one skid entry, so the
// upstream ready is a plain register with no path from out_ready.
// Also selects the write-back result, gates per-lane write enables and counts
// stalled cycles for performance debug.
//   clk            in   stage clock, all state on the falling edge
//   reset          in   asynchronous, active-low
//   flush          in   synchronous discard of all held entries
//   in_valid/ready      producer handshake
//   in_regwrite, in_memtoreg, in_flagswrite, in_lane_mask, in_wa3,
//   in_flags, in_readdata, in_aluout        entry fields
//   out_valid/ready     consumer handshake
//   out_wa3, out_lane_we, out_flags_we, out_flags, out_result
//                       fields derived from the main entry
//   stall_cnt      out  saturating count of edges with out_valid & !out_ready
// ----------------------------------------------------------------------------
module segment_vec_skid
    import vec_pipe_pkg::*;
#(
    parameter int N  = LANE_N,
    parameter int R  = LANES,
    parameter int A  = ADDR_W,
    parameter int F  = FLAG_W,
    parameter int CW = STALL_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_regwrite,
    input  logic          in_memtoreg,
    input  logic          in_flagswrite,
    input  logic [R-1:0]   in_lane_mask,
    input  logic [A-1:0]   in_wa3,
    input  logic [R*F-1:0] in_flags,
    input  logic [R*N-1:0] in_readdata,
    input  logic [R*N-1:0] in_aluout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [A-1:0]   out_wa3,
    output logic [R-1:0]   out_lane_we,
    output logic          out_flags_we,
    output logic [R*F-1:0] out_flags,
    output logic [R*N-1:0] out_result,
    output logic [CW-1:0]  stall_cnt
);

    // Same layout as seg_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic          flagswrite;
        logic [R-1:0]   lane_mask;
        logic [A-1:0]   wa3;
        logic [R*F-1:0] flags;
        logic [R*N-1:0] readdata;
        logic [R*N-1:0] aluout;
    } entry_t;

    localparam int EW = $bits(entry_t);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    entry_t in_entry, main_q, skid_q, main_d;
    logic   main_v, skid_v;
    logic   accept, drain;
    logic   main_load, main_clear, skid_load, skid_clear;

    assign in_entry = '{regwrite:   in_regwrite,
                        memtoreg:   in_memtoreg,
                        flagswrite: in_flagswrite,
                        lane_mask:  in_lane_mask,
                        wa3:        in_wa3,
                        flags:      in_flags,
                        readdata:   in_readdata,
                        aluout:     in_aluout};

    // skid_v is a flop, so in_ready is registered by construction.
    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready;
    assign drain    = main_v & out_ready;

    // ---- stage boundary: slot control, captured on the falling edge ----
    // The skid can only be full while main is full, and then in_ready=0,
    // so a drain refills main from the skid or from the new accept, never both.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d     = skid_v ? skid_q : in_entry;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (!main_v) begin
            main_load  = accept;
        end else if (drain) begin
            main_load  = skid_v | accept;
            main_clear = ~skid_v & ~accept;
            skid_clear = skid_v;
        end else begin
            skid_load  = accept;
        end
    end

    seg_entry_reg #(.W(EW)) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (main_load),
        .clear (main_clear),
        .d     (main_d),
        .valid (main_v),
        .q     (main_q)
    );

    seg_entry_reg #(.W(EW)) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     (in_entry),
        .valid (skid_v),
        .q     (skid_q)
    );

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (main_v && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    // ---- stage boundary: combinational outputs from the main entry ----
    assign out_valid    = main_v;
    assign out_wa3      = main_q.wa3;
    assign out_flags    = main_q.flags;
    assign out_lane_we  = {R{main_v & main_q.regwrite}} & main_q.lane_mask;
    assign out_flags_we = main_v & main_q.flagswrite & (|main_q.lane_mask);

    always_comb begin
        out_result = '0;
        for (int i = 0; i < R; i++) begin
            if (main_q.lane_mask[i]) begin
                out_result[i*N +: N] = main_q.memtoreg ? main_q.readdata[i*N +: N]
                                                       : main_q.aluout[i*N +: N];
            end
        end
    end

endmodule

// File: tb/tb_segment_vec_skid.sv
module tb_segment_vec_skid;

    localparam int N = 8, R = 6, A = 4, F = 2, CW = 4;

    typedef struct packed {
        logic          regwrite;
        logic          memtoreg;
        logic          flagswrite;
        logic [R-1:0]   mask;
        logic [A-1:0]   wa3;
        logic [R*F-1:0] flags;
        logic [R*N-1:0] rd;
        logic [R*N-1:0] alu;
    } stim_t;

    typedef struct packed {
        logic [A-1:0]   wa3;
        logic [R-1:0]   we;
        logic           fwe;
        logic [R*F-1:0] flags;
        logic [R*N-1:0] res;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_regwrite = 1'b0, in_memtoreg = 1'b0, in_flagswrite = 1'b0;
    logic [R-1:0]   in_lane_mask = '0;
    logic [A-1:0]   in_wa3 = '0;
    logic [R*F-1:0] in_flags = '0;
    logic [R*N-1:0] in_readdata = '0, in_aluout = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [A-1:0]   out_wa3;
    logic [R-1:0]   out_lane_we;
    logic          out_flags_we;
    logic [R*F-1:0] out_flags;
    logic [R*N-1:0] out_result;
    logic [CW-1:0]  stall_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    segment_vec_skid #(.N(N), .R(R), .A(A), .F(F), .CW(CW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_flagswrite(in_flagswrite),
        .in_lane_mask(in_lane_mask), .in_wa3(in_wa3), .in_flags(in_flags),
        .in_readdata(in_readdata), .in_aluout(in_aluout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wa3(out_wa3), .out_lane_we(out_lane_we), .out_flags_we(out_flags_we),
        .out_flags(out_flags), .out_result(out_result), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input stim_t s);
        exp_t e;
        e.wa3   = s.wa3;
        e.flags = s.flags;
        e.we    = s.regwrite ? s.mask : '0;
        e.fwe   = s.flagswrite & (|s.mask);
        e.res   = '0;
        for (int i = 0; i < R; i++)
            if (s.mask[i]) e.res[i*N +: N] = s.memtoreg ? s.rd[i*N +: N] : s.alu[i*N +: N];
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.regwrite   = 1'($urandom);
        s.memtoreg   = 1'($urandom);
        s.flagswrite = 1'($urandom);
        s.mask       = R'($urandom);
        s.wa3        = A'($urandom);
        s.flags      = (R*F)'($urandom);
        s.rd         = (R*N)'({$urandom, $urandom});
        s.alu        = (R*N)'({$urandom, $urandom});
        return s;
    endfunction

    // Drive one cycle starting at a rising edge; the DUT captures at the
    // following falling edge. Handshakes are resolved against the stable
    // pre-edge state; returns at the next rising edge.
    task automatic cycle(input stim_t s, input bit v, input bit ordy, input bit fl,
                         output bit acc);
        exp_t e;
        in_regwrite   = s.regwrite;
        in_memtoreg   = s.memtoreg;
        in_flagswrite = s.flagswrite;
        in_lane_mask  = s.mask;
        in_wa3        = s.wa3;
        in_flags      = s.flags;
        in_readdata   = s.rd;
        in_aluout     = s.alu;
        in_valid      = v;
        out_ready     = ordy;
        flush         = fl;
        #1;
        acc = 1'b0;
        if (fl) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got output wa3=%h with nothing expected", out_wa3);
                end else begin
                    e = sb.pop_front();
                    if ({out_wa3, out_lane_we, out_flags_we, out_flags, out_result} !== e) begin
                        errors++;
                        $display("FAIL sb_out: got %h expected %h",
                                 {out_wa3, out_lane_we, out_flags_we, out_flags, out_result}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(s));
                acc = 1'b1;
            end
        end
        @(posedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        sb.delete();
        #2;
        reset = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk);
        reset_dut();
        checks++;
        if ({out_valid, in_ready, stall_cnt, out_lane_we, out_flags_we, out_result} !==
            {1'b0, 1'b1, {CW{1'b0}}, {R{1'b0}}, 1'b0, {(R*N){1'b0}}}) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b st=%0d we=%b fwe=%b res=%h required v=0 rdy=1 st=0 we=0 fwe=0 res=0",
                     out_valid, in_ready, stall_cnt, out_lane_we, out_flags_we, out_result);
        end
    endtask

    task automatic test_single();
        stim_t s;
        bit acc;
        s = '0;
        s.regwrite = 1'b1;
        s.mask     = 6'b000001;
        s.wa3      = 4'h3;
        s.alu      = 48'h111111_11115A;
        s.rd       = 48'hEEEEEE_EEEEEE;
        cycle(s, 1'b1, 1'b1, 1'b0, acc);
        checks++;
        if ({out_valid, out_lane_we, out_result} !== {1'b1, 6'b000001, 48'h5A}) begin
            errors++;
            $display("FAIL single_lane0: got v=%b we=%b res=%h required v=1 we=000001 res=%h",
                     out_valid, out_lane_we, out_result, 48'h5A);
        end
        cycle('0, 1'b0, 1'b1, 1'b0, acc);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drained: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        stim_t e1, e2, e3;
        bit acc, e3_done;
        reset_dut();
        e1 = rand_stim(); e2 = rand_stim(); e3 = rand_stim();
        cycle(e1, 1'b1, 1'b0, 1'b0, acc);
        checks++;
        if ({out_valid, in_ready, stall_cnt} !== {1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL bp_e1: got v=%b rdy=%b st=%0d required v=1 rdy=1 st=0", out_valid, in_ready, stall_cnt);
        end
        cycle(e2, 1'b1, 1'b0, 1'b0, acc);
        checks++;
        if ({in_ready, stall_cnt} !== {1'b0, 4'd1}) begin
            errors++;
            $display("FAIL bp_e2_skid: got rdy=%b st=%0d required rdy=0 st=1", in_ready, stall_cnt);
        end
        cycle(e3, 1'b1, 1'b0, 1'b0, acc);
        checks++;
        if ({acc, in_ready, stall_cnt} !== {1'b0, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL bp_e3_held: got acc=%b rdy=%b st=%0d required acc=0 rdy=0 st=2", acc, in_ready, stall_cnt);
        end
        cycle(e3, 1'b1, 1'b0, 1'b0, acc);
        checks++;
        if (stall_cnt !== 4'd3) begin
            errors++;
            $display("FAIL bp_stall3: got %0d required 3", stall_cnt);
        end
        e3_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(e3, !e3_done, 1'b1, 1'b0, acc);
            if (acc) e3_done = 1'b1;
        end
        checks++;
        if ({e3_done, out_valid, stall_cnt, in_ready} !== {1'b1, 1'b0, 4'd3, 1'b1} || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got e3acc=%b v=%b st=%0d rdy=%b pending=%0d required 1 0 3 1 0",
                     e3_done, out_valid, stall_cnt, in_ready, sb.size());
        end
    endtask

    task automatic test_flush();
        bit acc;
        reset_dut();
        cycle(rand_stim(), 1'b1, 1'b0, 1'b0, acc);
        cycle(rand_stim(), 1'b1, 1'b0, 1'b0, acc);
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL flush_fill: got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
        end
        cycle(rand_stim(), 1'b1, 1'b1, 1'b1, acc);
        checks++;
        if ({out_valid, in_ready, out_lane_we, out_flags_we} !== {1'b0, 1'b1, {R{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL flush_clear: got v=%b rdy=%b we=%b fwe=%b required v=0 rdy=1 we=0 fwe=0",
                     out_valid, in_ready, out_lane_we, out_flags_we);
        end
        cycle('0, 1'b0, 1'b1, 1'b0, acc);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_store: got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_result_select();
        stim_t s;
        bit acc;
        s = '0;
        s.memtoreg   = 1'b1;
        s.flagswrite = 1'b1;
        s.mask       = 6'b111111;
        s.flags      = 12'hABC;
        s.rd         = 48'h0102030405_06;
        s.alu        = 48'hAAAAAA_AAAAAA;
        cycle(s, 1'b1, 1'b1, 1'b0, acc);
        checks++;
        if ({out_result, out_lane_we, out_flags_we, out_flags} !== {48'h010203040506, 6'b0, 1'b1, 12'hABC}) begin
            errors++;
            $display("FAIL sel_readdata: got res=%h we=%b fwe=%b fl=%h required res=010203040506 we=0 fwe=1 fl=abc",
                     out_result, out_lane_we, out_flags_we, out_flags);
        end
        s.regwrite = 1'b1;
        s.mask     = '0;
        s.rd       = 48'hFFFFFF_FFFFFF;
        s.alu      = '0;
        cycle(s, 1'b1, 1'b1, 1'b0, acc);
        checks++;
        if ({out_valid, out_result, out_lane_we, out_flags_we} !== {1'b1, 48'h0, 6'b0, 1'b0}) begin
            errors++;
            $display("FAIL mask_zero: got v=%b res=%h we=%b fwe=%b required v=1 res=0 we=0 fwe=0",
                     out_valid, out_result, out_lane_we, out_flags_we);
        end
        cycle('0, 1'b0, 1'b1, 1'b0, acc);
    endtask

    task automatic test_back_to_back();
        stim_t s;
        bit acc, pend;
        reset_dut();
        pend = 1'b0;
        s = '0;
        for (int i = 0; i < 80; i++) begin
            if (!pend) s = rand_stim();
            pend = ($urandom_range(0, 3) != 0);
            cycle(s, pend, ($urandom_range(0, 2) != 0), 1'b0, acc);
            if (acc) pend = 1'b0;
        end
        for (int i = 0; i < 6; i++) cycle('0, 1'b0, 1'b1, 1'b0, acc);
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_complete: got v=%b pending=%0d required v=0 pending=0", out_valid, sb.size());
        end
    endtask

    task automatic test_stall_saturate();
        bit acc;
        reset_dut();
        cycle(rand_stim(), 1'b1, 1'b0, 1'b0, acc);
        cycle(rand_stim(), 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 20; i++) cycle('0, 1'b0, 1'b0, 1'b0, acc);
        checks++;
        if ({stall_cnt, in_ready} !== {4'd15, 1'b0}) begin
            errors++;
            $display("FAIL stall_sat: got st=%0d rdy=%b required st=15 rdy=0", stall_cnt, in_ready);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, stall_cnt, out_lane_we, out_flags_we, out_result} !==
            {1'b0, 1'b1, {CW{1'b0}}, {R{1'b0}}, 1'b0, {(R*N){1'b0}}}) begin
            errors++;
            $display("FAIL async_reset: got v=%b rdy=%b st=%0d we=%b fwe=%b res=%h required all cleared, rdy=1",
                     out_valid, in_ready, stall_cnt, out_lane_we, out_flags_we, out_result);
        end
        sb.delete();
        #1;
        reset = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_flush();
        test_result_select();
        test_back_to_back();
        test_stall_saturate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
